// File: rtl/matrix_spi_pkg.sv
// matrix_spi_pkg
// Shared definitions for the matrix accelerator SPI ingress path: the
// receiver state encoding, the header word layout and the SPI word width.
// No ports (package).
package matrix_spi_pkg;

  localparam int WORD_W      = 32;
  localparam int HDR_FIELD_W = 8;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  // Header word layout: magic | M | K | N, most significant byte first
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_M_LSB     = 16;
  localparam int HDR_K_LSB     = 8;
  localparam int HDR_N_LSB     = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_HDR = 3'd1,
    ST_RECV_A   = 3'd2,
    ST_RECV_B   = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } rx_state_t;

  // States in which the receiver is willing to take a word from the SPI engine
  function automatic logic is_recv_state(input rx_state_t s);
    return (s == ST_WAIT_HDR) || (s == ST_RECV_A) || (s == ST_RECV_B);
  endfunction

endpackage

// File: rtl/spi_slave.sv
// spi_slave
// SPI mode-0 slave word engine, MSB first, one WORD_W-bit word per
// chip-select frame. sclk, mosi and cs_n are synchronised into the clk
// domain, so sclk must be several times slower than clk.
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   sclk, mosi, cs_n   SPI bus from the master
//   miso               SPI data out, low whenever nothing is being sent
//   tx_valid, tx_data  word to send in the next frame (sampled at frame start)
//   rx_data, rx_valid  received word, held until taken
//   rx_ready           consumer handshake; word taken when rx_valid && rx_ready
module spi_slave
  import matrix_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  input  logic              tx_valid,
  input  logic [WORD_W-1:0] tx_data,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready
);

  localparam logic [5:0] FULL_CNT = 6'(WORD_W);

  logic [2:0]        sclk_sync;
  logic [2:0]        cs_sync;
  logic [1:0]        mosi_sync;
  logic [5:0]        bit_cnt;
  logic [WORD_W-1:0] rx_shift;
  logic [WORD_W-1:0] tx_shift;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              frame_start;
  logic              frame_end;
  logic              cs_active;

  // mosi uses the same synchroniser depth as sclk so the sampled bit lines
  // up with the detected rising edge
  assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
  assign frame_start = ~cs_sync[1] & cs_sync[2];
  assign frame_end   = cs_sync[1] & ~cs_sync[2];
  assign cs_active   = ~cs_sync[1];

  assign miso = cs_active ? tx_shift[WORD_W-1] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  // The bit counter saturates one past a full word so an over-long frame is
  // recognised as malformed and dropped at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else if (frame_start) begin
      bit_cnt  <= '0;
      tx_shift <= tx_valid ? tx_data : '0;
    end else if (cs_active) begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[WORD_W-2:0], mosi_sync[1]};
        if (bit_cnt != FULL_CNT + 6'd1) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
      if (sclk_fall) begin
        tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
      end
    end
  end

  // Holding register: the word stays valid until the consumer takes it; a
  // newer complete word replaces an unclaimed one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (frame_end && (bit_cnt == FULL_CNT)) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_matrix_receiver.sv
// spi_matrix_receiver
// SPI ingress for the matrix accelerator. After a start_rx arm pulse it takes
// a header word (magic, M, K, N) followed by M*K words of A and K*N words of B,
// storing both row-major, then pulses done_rx. A bad header pulses err_rx.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sclk, mosi, cs_n      SPI bus from the master
//   miso                  SPI data out, idle (transmit path unused)
//   start_rx              single-cycle arm pulse, honoured only when idle
//   matrix_A, matrix_B    received elements, row-major
//   dim_M, dim_K, dim_N   dimensions from the last accepted header
//   busy                  high from arm until the DONE/ERR cycle
//   done_rx, err_rx       one-cycle completion / header-error pulses
module spi_matrix_receiver
  import matrix_spi_pkg::*;
#(
  parameter int MAX_M = 10,
  parameter int MAX_K = 10,
  parameter int MAX_N = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  input  logic              start_rx,
  output logic [WORD_W-1:0] matrix_A [0:MAX_M*MAX_K-1],
  output logic [WORD_W-1:0] matrix_B [0:MAX_K*MAX_N-1],
  output logic [7:0]        dim_M,
  output logic [7:0]        dim_K,
  output logic [7:0]        dim_N,
  output logic              busy,
  output logic              done_rx,
  output logic              err_rx
);

  localparam int SIZE_A = MAX_M * MAX_K;
  localparam int SIZE_B = MAX_K * MAX_N;
  localparam int A_AW   = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int B_AW   = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

  localparam logic [7:0] MAX_M8 = 8'(MAX_M);
  localparam logic [7:0] MAX_K8 = 8'(MAX_K);
  localparam logic [7:0] MAX_N8 = 8'(MAX_N);

  rx_state_t         state;
  rx_state_t         state_next;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              accept;
  logic [15:0]       idx;
  logic [15:0]       size_a;
  logic [15:0]       size_b;
  logic [7:0]        hdr_magic;
  logic [7:0]        hdr_m;
  logic [7:0]        hdr_k;
  logic [7:0]        hdr_n;
  logic              hdr_ok;

  spi_slave u_spi_slave (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .miso     (miso),
    .tx_valid (1'b0),
    .tx_data  ('0),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  assign accept = rx_valid && rx_ready;

  assign hdr_magic = rx_data[HDR_MAGIC_LSB +: HDR_FIELD_W];
  assign hdr_m     = rx_data[HDR_M_LSB +: HDR_FIELD_W];
  assign hdr_k     = rx_data[HDR_K_LSB +: HDR_FIELD_W];
  assign hdr_n     = rx_data[HDR_N_LSB +: HDR_FIELD_W];

  assign hdr_ok = (hdr_magic == HDR_MAGIC) &&
                  (hdr_m != 8'd0) && (hdr_m <= MAX_M8) &&
                  (hdr_k != 8'd0) && (hdr_k <= MAX_K8) &&
                  (hdr_n != 8'd0) && (hdr_n <= MAX_N8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // rx_ready is dropped in the cycle after the final word of a phase so the
  // engine is never handshaken while the FSM is in DONE/ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready <= 1'b0;
    end else begin
      rx_ready <= is_recv_state(state) && is_recv_state(state_next);
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done_rx    = 1'b0;
    err_rx     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rx) begin
          state_next = ST_WAIT_HDR;
        end
      end
      ST_WAIT_HDR: begin
        busy = 1'b1;
        if (accept) begin
          state_next = hdr_ok ? ST_RECV_A : ST_ERR;
        end
      end
      ST_RECV_A: begin
        busy = 1'b1;
        if (accept && (idx == size_a - 16'd1)) begin
          state_next = ST_RECV_B;
        end
      end
      ST_RECV_B: begin
        busy = 1'b1;
        if (accept && (idx == size_b - 16'd1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done_rx    = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        err_rx     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Dimensions, index and element storage. Entries past the current sizes are
  // left untouched so a smaller transfer only overwrites its own prefix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_M  <= '0;
      dim_K  <= '0;
      dim_N  <= '0;
      size_a <= '0;
      size_b <= '0;
      idx    <= '0;
      for (int i = 0; i < SIZE_A; i++) begin
        matrix_A[i] <= '0;
      end
      for (int i = 0; i < SIZE_B; i++) begin
        matrix_B[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rx) begin
            idx <= '0;
          end
        end
        ST_WAIT_HDR: begin
          if (accept && hdr_ok) begin
            dim_M  <= hdr_m;
            dim_K  <= hdr_k;
            dim_N  <= hdr_n;
            size_a <= 16'(hdr_m) * 16'(hdr_k);
            size_b <= 16'(hdr_k) * 16'(hdr_n);
            idx    <= '0;
          end
        end
        ST_RECV_A: begin
          if (accept) begin
            matrix_A[idx[A_AW-1:0]] <= rx_data;
            idx <= (idx == size_a - 16'd1) ? 16'd0 : idx + 16'd1;
          end
        end
        ST_RECV_B: begin
          if (accept) begin
            matrix_B[idx[B_AW-1:0]] <= rx_data;
            idx <= (idx == size_b - 16'd1) ? 16'd0 : idx + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
